// File: rtl/tdm_voice_nco_if.sv
// Control and wavetable-address bundle between the voice sequencer and the
// time-division NCO bank.
interface tdm_voice_nco_if #(
  parameter int VOICES      = 8,
  parameter int VOICES_BITS = 3,
  parameter int ACC_W       = 24,
  parameter int ADDR_W      = 8
);
  logic                   sample_tick;
  logic                   inc_we;
  logic [VOICES_BITS-1:0] inc_sel;
  logic [ACC_W-1:0]       inc_data;
  logic [VOICES-1:0]      voice_gate;
  logic [ADDR_W-1:0]      nco_addr_out;
  logic [VOICES_BITS-1:0] voice_idx;
  logic                   addr_valid;
  logic                   voice_active;
  logic                   frame_done;
  logic                   busy;
  logic                   overrun;

  modport master (
    output sample_tick, inc_we, inc_sel, inc_data, voice_gate,
    input  nco_addr_out, voice_idx, addr_valid, voice_active,
           frame_done, busy, overrun
  );

  modport slave (
    input  sample_tick, inc_we, inc_sel, inc_data, voice_gate,
    output nco_addr_out, voice_idx, addr_valid, voice_active,
           frame_done, busy, overrun
  );
endinterface

// File: rtl/tdm_voice_nco.sv
// Time-division phase accumulator bank: one wavetable address per voice per
// sample tick, each voice occupying an address cycle and a BRAM data cycle.
module tdm_voice_nco #(
  parameter int VOICES      = 8,
  parameter int VOICES_BITS = 3,
  parameter int ACC_W       = 24,
  parameter int ADDR_W      = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  tdm_voice_nco_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [VOICES_BITS-1:0] v_q, v_d;
  logic [ACC_W-1:0]       acc_q [VOICES];
  logic [ACC_W-1:0]       acc_d [VOICES];
  logic [ACC_W-1:0]       inc_q [VOICES];
  logic [ACC_W-1:0]       inc_d [VOICES];
  logic [ADDR_W-1:0]      nco_addr_q, nco_addr_d;
  logic [VOICES_BITS-1:0] voice_idx_q, voice_idx_d;
  logic                   addr_valid_q, addr_valid_d;
  logic                   voice_active_q, voice_active_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   enter_addr;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    v_d            = v_q;
    acc_d          = acc_q;
    inc_d          = inc_q;
    nco_addr_d     = nco_addr_q;
    voice_idx_d    = voice_idx_q;
    voice_active_d = voice_active_q;
    addr_valid_d   = 1'b0;
    frame_done_d   = 1'b0;
    enter_addr     = 1'b0;
    overrun_d      = overrun_q | (bus.sample_tick && (state_q != IDLE));

    // A write landing during the voice's address cycle commits alongside the
    // accumulator update, which still reads the old increment.
    if (bus.inc_we) inc_d[bus.inc_sel] = bus.inc_data;

    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          state_d    = ADDR;
          v_d        = '0;
          enter_addr = 1'b1;
        end
      end
      ADDR: begin
        state_d   = HOLD;
        acc_d[v_q] = voice_active_q ? acc_q[v_q] + inc_q[v_q] : '0;
      end
      HOLD: begin
        if (v_q == VOICES_BITS'(VOICES - 1)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d    = ADDR;
          v_d        = v_q + 1'b1;
          enter_addr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the address-cycle values are prepared on
    // the edge that enters ADDR.
    if (enter_addr) begin
      addr_valid_d   = 1'b1;
      voice_idx_d    = v_d;
      voice_active_d = bus.voice_gate[v_d];
      nco_addr_d     = bus.voice_gate[v_d] ? acc_q[v_d][ACC_W-1 -: ADDR_W] : '0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: the accumulator and increment arrays are reset explicitly because
  // the bank must restart from phase 0 with zero increments after reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      v_q            <= '0;
      acc_q          <= '{default: '0};
      inc_q          <= '{default: '0};
      nco_addr_q     <= '0;
      voice_idx_q    <= '0;
      addr_valid_q   <= 1'b0;
      voice_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      v_q            <= v_d;
      acc_q          <= acc_d;
      inc_q          <= inc_d;
      nco_addr_q     <= nco_addr_d;
      voice_idx_q    <= voice_idx_d;
      addr_valid_q   <= addr_valid_d;
      voice_active_q <= voice_active_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.nco_addr_out = nco_addr_q;
  assign bus.voice_idx    = voice_idx_q;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.voice_active = voice_active_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_tdm_voice_nco.sv
// Directed bench for tdm_voice_nco: frame tables of hand-computed addresses
// plus sequences for overrun, increment write hazard and mid-frame reset.
module tb_tdm_voice_nco;
  localparam int VOICES      = 8;
  localparam int VOICES_BITS = 3;
  localparam int ACC_W       = 24;
  localparam int ADDR_W      = 8;

  typedef struct {
    logic [VOICES-1:0]             gate;
    logic [VOICES-1:0][ADDR_W-1:0] addr;
  } frame_vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 sys_clk = ~sys_clk;

  tdm_voice_nco_if #(
    .VOICES(VOICES), .VOICES_BITS(VOICES_BITS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) bus ();

  tdm_voice_nco #(
    .VOICES(VOICES), .VOICES_BITS(VOICES_BITS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_inc(input logic [VOICES_BITS-1:0] sel, input logic [ACC_W-1:0] data);
    bus.inc_we   = 1'b1;
    bus.inc_sel  = sel;
    bus.inc_data = data;
    step();
    bus.inc_we   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},         32'(bus.busy),         32'd0);
    check({tag, ".addr_valid"},   32'(bus.addr_valid),   32'd0);
    check({tag, ".voice_idx"},    32'(bus.voice_idx),    32'd0);
    check({tag, ".nco_addr"},     32'(bus.nco_addr_out), 32'd0);
    check({tag, ".voice_active"}, 32'(bus.voice_active), 32'd0);
    check({tag, ".frame_done"},   32'(bus.frame_done),   32'd0);
    check({tag, ".overrun"},      32'(bus.overrun),      32'd0);
  endtask

  // Tick sampled at cycle T; observation points are T+1 .. T+18.
  task automatic run_frame(input string tag, input logic [VOICES-1:0] gate,
                           input logic [VOICES-1:0][ADDR_W-1:0] exp_addr);
    bus.voice_gate  = gate;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      check($sformatf("%s.v%0d.addr_valid", tag, v), 32'(bus.addr_valid),   32'd1);
      check($sformatf("%s.v%0d.voice_idx", tag, v),  32'(bus.voice_idx),    32'(v));
      check($sformatf("%s.v%0d.nco_addr", tag, v),   32'(bus.nco_addr_out), 32'(exp_addr[v]));
      check($sformatf("%s.v%0d.active", tag, v),     32'(bus.voice_active), 32'(gate[v]));
      check($sformatf("%s.v%0d.busy", tag, v),       32'(bus.busy),         32'd1);
      step();
      check($sformatf("%s.v%0d.hold_valid", tag, v), 32'(bus.addr_valid),   32'd0);
      check($sformatf("%s.v%0d.hold_addr", tag, v),  32'(bus.nco_addr_out), 32'(exp_addr[v]));
      check($sformatf("%s.v%0d.hold_idx", tag, v),   32'(bus.voice_idx),    32'(v));
      check($sformatf("%s.v%0d.hold_done", tag, v),  32'(bus.frame_done),   32'd0);
      step();
    end
    check({tag, ".frame_done"},  32'(bus.frame_done), 32'd1);
    check({tag, ".end_busy"},    32'(bus.busy),       32'd0);
    check({tag, ".end_valid"},   32'(bus.addr_valid), 32'd0);
    step();
    check({tag, ".done_pulse"},  32'(bus.frame_done), 32'd0);
    step();
  endtask

  function automatic frame_vec_t mk(input logic [VOICES-1:0] g, input logic [ADDR_W-1:0] a0,
                                    input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a3);
    frame_vec_t r;
    r.gate    = g;
    r.addr    = '0;
    r.addr[0] = a0;
    r.addr[1] = a1;
    r.addr[3] = a3;
    return r;
  endfunction

  frame_vec_t vecs[6];

  initial begin
    // inc0=0x010000, inc1=0xFF0000 (wraps), inc3=0x020000; voice 0 gated off in frame 4.
    vecs[0] = mk(8'hFF, 8'h00, 8'h00, 8'h00);
    vecs[1] = mk(8'hFF, 8'h01, 8'hFF, 8'h02);
    vecs[2] = mk(8'hFF, 8'h02, 8'hFE, 8'h04);
    vecs[3] = mk(8'hFE, 8'h00, 8'hFD, 8'h06);
    vecs[4] = mk(8'hFF, 8'h00, 8'hFC, 8'h08);
    vecs[5] = mk(8'hFF, 8'h01, 8'hFB, 8'h0A);

    sys_rst_n       = 1'b0;
    bus.sample_tick = 1'b0;
    bus.inc_we      = 1'b0;
    bus.inc_sel     = '0;
    bus.inc_data    = '0;
    bus.voice_gate  = '0;
    step();
    step();
    check_idle_outputs("reset");
    sys_rst_n = 1'b1;
    step();

    run_frame("gated_off", 8'h00, '0);

    write_inc(3'd0, 24'h010000);
    write_inc(3'd1, 24'hFF0000);
    write_inc(3'd3, 24'h020000);
    step();

    for (int i = 0; i < 6; i++) run_frame($sformatf("tbl%0d", i), vecs[i].gate, vecs[i].addr);

    // Overrun tick at T+3 and an inc0 write during voice 0's address cycle.
    bus.voice_gate  = 8'hFF;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check("hazard.addr_v0", 32'(bus.nco_addr_out), 32'h02);
    bus.inc_we   = 1'b1;
    bus.inc_sel  = 3'd0;
    bus.inc_data = 24'h080000;
    step();
    bus.inc_we = 1'b0;
    step();
    check("ovr.before", 32'(bus.overrun), 32'd0);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check("ovr.set", 32'(bus.overrun), 32'd1);
    for (int k = 0; k < 12; k++) step();
    check("ovr.done_not_early", 32'(bus.frame_done), 32'd0);
    check("ovr.busy_t16",       32'(bus.busy),       32'd1);
    step();
    check("ovr.done_t17",       32'(bus.frame_done), 32'd1);
    step();
    step();

    run_frame("hazard_old_inc", 8'hFF, mk(8'hFF, 8'h03, 8'hF9, 8'h0E).addr);
    run_frame("hazard_new_inc", 8'hFF, mk(8'hFF, 8'h0B, 8'hF8, 8'h10).addr);
    check("ovr.sticky", 32'(bus.overrun), 32'd1);

    // Reset sampled at the end of T+6.
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("midrst.busy_before", 32'(bus.busy), 32'd1);
    sys_rst_n = 1'b0;
    step();
    check_idle_outputs("midrst");
    sys_rst_n = 1'b1;
    step();
    run_frame("post_rst1", 8'hFF, '0);
    run_frame("post_rst2", 8'hFF, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
